// File: rtl/ipg_tx_mc.sv
// ipg_tx_mc: 64b/66b TX IPG insertion stage with per-channel FIFOs and RR arbitration.
// Build option IPG_IDLE_REPLACE_EN: idle ctrl blocks in the gap may carry chunks.
module ipg_tx_mc #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TUSER_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         netq_write,
  input  logic [HDR_WIDTH-1:0]         encoded_tx_hdr,
  input  logic [DATA_WIDTH-1:0]        encoded_tx_data,
  input  logic [NUM_CH-1:0]            chq_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chq_data,
  output logic [NUM_CH-1:0]            chq_ready,
  output logic [DATA_WIDTH-1:0]        proced_encoded_tx_data,
  output logic [HDR_WIDTH-1:0]         proced_encoded_tx_hdr,
  output logic                         proced_valid,
  output logic [TUSER_W-1:0]           tuser,
  output logic                         in_gap
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = HDR_WIDTH'(1);
  localparam logic [CNTW-1:0]      FULL      = CNTW'(FIFO_DEPTH);

  typedef enum logic {GAP = 1'b0, FRAME = 1'b1} gap_e;

  gap_e state_q, state_d;

  logic [7:0] blk_type;
  logic       net_ctrl;
  logic       gap_now;

  assign blk_type = encoded_tx_data[7:0];
  assign net_ctrl = netq_write && (encoded_tx_hdr == SYNC_CTRL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= GAP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (net_ctrl) begin
      case (blk_type)
        8'h78, 8'h33, 8'h66: state_d = FRAME;
        8'h87, 8'h99, 8'haa, 8'hb4,
        8'hcc, 8'hd2, 8'he1, 8'hff: state_d = GAP;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    gap_now = (state_q == GAP);
    in_gap  = gap_now;
  end

  logic [NUM_CH-1:0]            nonempty;
  logic [NUM_CH*DATA_WIDTH-1:0] head_flat;
  logic [CW-1:0]                rr_q, rr_d, gnt;
  logic                         gnt_vld;
  logic [CW:0]                  idx;
  logic                         idle_slot;
  logic                         pop_en;

`ifdef IPG_IDLE_REPLACE_EN
  assign idle_slot = net_ctrl && (blk_type == 8'h1e);
`else
  assign idle_slot = 1'b0;
`endif

  assign pop_en = gap_now && gnt_vld && (!netq_write || idle_slot);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic                  wr, rd;

    assign wr = chq_write[i] && (cnt_q != FULL);
    assign rd = pop_en && (gnt == CW'(i));

    always_comb begin
      cnt_d = cnt_q;
      if (wr && !rd)      cnt_d = cnt_q + CNTW'(1);
      else if (!wr && rd) cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (wr) wptr_q <= wptr_q + PW'(1);
        if (rd) rptr_q <= rptr_q + PW'(1);
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset; an empty count makes stale entries invisible.
    always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= chq_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign nonempty[i] = (cnt_q != '0);
    assign chq_ready[i] = (cnt_q != FULL);
    assign head_flat[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rptr_q];
  end

  // Scan downwards so the channel closest to the pointer wins.
  always_comb begin
    gnt     = rr_q;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int o = NUM_CH - 1; o >= 0; o--) begin
      idx = {1'b0, rr_q} + (CW+1)'(o);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (nonempty[idx[CW-1:0]]) begin
        gnt     = idx[CW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (pop_en) rr_d = (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_q <= '0;
    else          rr_q <= rr_d;
  end

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [TUSER_W-1:0]    tuser_q, tuser_d;
  logic                  valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    hdr_d   = hdr_q;
    tuser_d = tuser_q;
    valid_d = 1'b0;
    if (pop_en) begin
      data_d  = head_flat[gnt*DATA_WIDTH +: DATA_WIDTH];
      hdr_d   = SYNC_CTRL;
      tuser_d = TUSER_W'(gnt) + TUSER_W'(1);
      valid_d = 1'b1;
    end else if (netq_write) begin
      data_d  = encoded_tx_data;
      hdr_d   = encoded_tx_hdr;
      tuser_d = '0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      hdr_q   <= '0;
      tuser_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      tuser_q <= tuser_d;
      valid_q <= valid_d;
    end
  end

  assign proced_encoded_tx_data = data_q;
  assign proced_encoded_tx_hdr  = hdr_q;
  assign tuser                  = tuser_q;
  assign proced_valid           = valid_q;

endmodule

// File: tb/tb_ipg_tx_mc.sv
// tb_ipg_tx_mc: directed + random bench for ipg_tx_mc against a queue-based model.
// Honours IPG_IDLE_REPLACE_EN the same way as the design.
module tb_ipg_tx_mc;
  localparam int DW = 64;
  localparam int HW = 2;
  localparam int NCH = 2;
  localparam int DEPTH = 4;
  localparam int TW = 3;
`ifdef IPG_IDLE_REPLACE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic netq_write = 1'b0;
  logic [HW-1:0] hdr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [NCH-1:0] wr_i = '0;
  logic [NCH*DW-1:0] cd_i = '0;
  logic [NCH-1:0] chq_ready;
  logic [DW-1:0] o_data;
  logic [HW-1:0] o_hdr;
  logic o_valid;
  logic [TW-1:0] o_tuser;
  logic in_gap;

  always #5 clk = ~clk;

  ipg_tx_mc #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .NUM_CH(NCH),
    .FIFO_DEPTH(DEPTH), .TUSER_W(TW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .netq_write(netq_write),
    .encoded_tx_hdr(hdr_i),
    .encoded_tx_data(data_i),
    .chq_write(wr_i),
    .chq_data(cd_i),
    .chq_ready(chq_ready),
    .proced_encoded_tx_data(o_data),
    .proced_encoded_tx_hdr(o_hdr),
    .proced_valid(o_valid),
    .tuser(o_tuser),
    .in_gap(in_gap)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] mq [NCH][$];
  bit m_gap;
  int m_rr;
  logic [63:0] e_data;
  logic [1:0] e_hdr;
  logic [2:0] e_tuser;
  bit e_valid;
  logic [68:0] outq [$];

  function automatic bit is_start(logic [7:0] t);
    return t inside {8'h78, 8'h33, 8'h66};
  endfunction

  function automatic bit is_term(logic [7:0] t);
    return t inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    m_gap = 1'b1;
    m_rr = 0;
    e_data = '0;
    e_hdr = '0;
    e_tuser = '0;
    e_valid = 1'b0;
  endtask

  task automatic model_step();
    int sz[NCH];
    bit any;
    bit slot;
    int g;
    int c;
    any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      sz[i] = mq[i].size();
      if (sz[i] > 0) any = 1'b1;
    end
    slot = !netq_write ||
           (IDLE_EN && hdr_i == 2'b01 && data_i[7:0] == 8'h1e);
    if (m_gap && any && slot) begin
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      e_data = mq[g].pop_front();
      e_hdr = 2'b01;
      e_tuser = 3'(g + 1);
      e_valid = 1'b1;
      m_rr = (g + 1) % NCH;
    end else if (netq_write) begin
      e_data = data_i;
      e_hdr = hdr_i;
      e_tuser = '0;
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
    for (int i = 0; i < NCH; i++)
      if (wr_i[i] && sz[i] < DEPTH) mq[i].push_back(cd_i[i*DW +: DW]);
    if (netq_write && hdr_i == 2'b01) begin
      if (is_start(data_i[7:0])) m_gap = 1'b0;
      else if (is_term(data_i[7:0])) m_gap = 1'b1;
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] e_rdy;
    for (int i = 0; i < NCH; i++) e_rdy[i] = (mq[i].size() < DEPTH);
    checks++;
    if (o_valid !== e_valid || o_data !== e_data || o_hdr !== e_hdr ||
        o_tuser !== e_tuser || in_gap !== m_gap || chq_ready !== e_rdy) begin
      failures++;
      $display("FAIL cycle%0d outputs: got v=%0b t=%0d h=%0d d=%h gap=%0b rdy=%b, want v=%0b t=%0d h=%0d d=%h gap=%0b rdy=%b",
               cyc, o_valid, o_tuser, o_hdr, o_data, in_gap, chq_ready,
               e_valid, e_tuser, e_hdr, e_data, m_gap, e_rdy);
    end
    if (o_valid === 1'b1) outq.push_back({o_tuser, o_hdr, o_data});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic drv(input bit nw, input logic [1:0] h, input logic [63:0] d,
                     input logic [1:0] w, input logic [63:0] c0,
                     input logic [63:0] c1);
    netq_write = nw;
    hdr_i = h;
    data_i = d;
    wr_i = w;
    cd_i = {c1, c0};
  endtask

  task automatic idle();
    drv(1'b0, 2'b00, 64'h0, 2'b00, 64'h0, 64'h0);
  endtask

  function automatic logic [68:0] get(int i);
    if (i < outq.size()) return outq[i];
    return {69{1'bx}};
  endfunction

  task automatic check_lit(input string nm, input logic [68:0] act,
                           input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check_lit(nm, {o_data, o_hdr, o_valid, o_tuser, in_gap, chq_ready},
              {64'h0, 2'b00, 1'b0, 3'd0, 1'b1, 2'b11});
  endtask

  task automatic rand_drive();
    logic [7:0] types [14];
    logic [63:0] d;
    logic [1:0] h;
    int r;
    types = '{8'h78, 8'h33, 8'h66, 8'h87, 8'h99, 8'haa, 8'hb4,
              8'hcc, 8'hd2, 8'he1, 8'hff, 8'h1e, 8'h4b, 8'h2d};
    d = {$urandom, $urandom};
    r = int'($urandom % 8);
    if (r < 4) begin
      h = 2'b01;
      d[7:0] = types[$urandom % 14];
    end else if (r < 6) h = 2'b10;
    else if (r == 6) h = 2'b00;
    else h = 2'b11;
    drv($urandom_range(0, 99) < 45, h, d, 2'($urandom % 4),
        {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  int n;

  initial begin
    model_reset();
    #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    reset_n = 1'b1;
    idle();
    repeat (3) tick();
    check_int("idle_no_output", outq.size(), 0);

    // Chunk written inside a frame waits for TERM.
    outq.delete();
    drv(1'b1, 2'b01, 64'h78, 2'b00, 64'h0, 64'h0); tick();
    drv(1'b1, 2'b10, 64'hbb11223344556677, 2'b10, 64'h0, 64'hccccaaaaccccaa1e); tick();
    drv(1'b1, 2'b01, 64'h000000000000aa99, 2'b00, 64'h0, 64'h0); tick();
    idle(); tick(); tick();
    check_lit("gap_term", get(2), {3'd0, 2'b01, 64'h000000000000aa99});
    check_lit("gap_chunk", get(3), {3'd2, 2'b01, 64'hccccaaaaccccaa1e});
    check_int("gap_count", outq.size(), 4);

    // Round robin A0,B0,A1,B1.
    outq.delete();
    drv(1'b1, 2'b10, 64'h1111, 2'b11, 64'haaaa0000aaaa0000, 64'hbbbb0000bbbb0000); tick();
    drv(1'b1, 2'b10, 64'h2222, 2'b11, 64'haaaa1111aaaa1111, 64'hbbbb1111bbbb1111); tick();
    idle(); repeat (5) tick();
    check_lit("rr_0", get(2), {3'd1, 2'b01, 64'haaaa0000aaaa0000});
    check_lit("rr_1", get(3), {3'd2, 2'b01, 64'hbbbb0000bbbb0000});
    check_lit("rr_2", get(4), {3'd1, 2'b01, 64'haaaa1111aaaa1111});
    check_lit("rr_3", get(5), {3'd2, 2'b01, 64'hbbbb1111bbbb1111});

    // Fill ch0 during a frame; the fifth write is lost.
    outq.delete();
    drv(1'b1, 2'b01, 64'h33, 2'b00, 64'h0, 64'h0); tick();
    for (int k = 0; k < 5; k++) begin
      drv(1'b0, 2'b00, 64'h0, 2'b01, 64'hf0 + 64'(k), 64'h0); tick();
      if (k == 3) check_int("full_ready", int'(chq_ready[0]), 0);
    end
    drv(1'b1, 2'b01, 64'hff, 2'b00, 64'h0, 64'h0); tick();
    idle(); repeat (6) tick();
    n = 0;
    foreach (outq[i]) if (outq[i][68:66] == 3'd1) n++;
    check_int("full_count", n, 4);
    check_lit("full_last", get(outq.size() - 1), {3'd1, 2'b01, 64'hf3});

    // Network block beats a pending chunk.
    outq.delete();
    drv(1'b0, 2'b00, 64'h0, 2'b10, 64'h0, 64'h5a5a); tick();
    drv(1'b1, 2'b10, 64'h1234, 2'b00, 64'h0, 64'h0); tick();
    idle(); tick(); tick();
    check_lit("prio_net", get(0), {3'd0, 2'b10, 64'h1234});
    check_lit("prio_chunk", get(1), {3'd2, 2'b01, 64'h5a5a});

    // Idle block in the gap.
    outq.delete();
    drv(1'b0, 2'b00, 64'h0, 2'b01, 64'h666666666666661e, 64'h0); tick();
    drv(1'b1, 2'b01, 64'h1e, 2'b00, 64'h0, 64'h0); tick();
    idle(); tick(); tick();
`ifdef IPG_IDLE_REPLACE_EN
    check_lit("idle_replaced", get(0), {3'd1, 2'b01, 64'h666666666666661e});
    check_int("idle_count", outq.size(), 1);
`else
    check_lit("idle_fwd", get(0), {3'd0, 2'b01, 64'h1e});
    check_lit("idle_chunk", get(1), {3'd1, 2'b01, 64'h666666666666661e});
`endif

    // Random traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset("mid_reset");
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
      end
      rand_drive();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ipg_tx_mc.md
# ipg_tx_mc

Parametrised multi-channel IPG insertion stage for the 64b/66b transmit path. Forwards the encoded network block stream unchanged and, only while the link is in an inter-packet gap, fills empty network slots with side-channel chunks (memory replies, requests, ...) taken from per-channel FIFOs under round-robin arbitration. Sits between the 64b/66b encoder output and the scrambler, and replaces the fixed two-source `ipg_tx`.

## Interface
Parameters:
- DATA_WIDTH, 64, block/chunk payload width
- HDR_WIDTH, 2, sync header width
- NUM_CH, 2, number of side channels (1..7)
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- TUSER_W, 3, tuser width (≥ clog2(NUM_CH+1))

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- netq_write  in  1  network block valid this cycle
- encoded_tx_hdr  in  HDR_WIDTH  network sync header
- encoded_tx_data  in  DATA_WIDTH  network block
- chq_write  in  NUM_CH  per-channel chunk write strobe
- chq_data  in  NUM_CH*DATA_WIDTH  channel i chunk at [i*DATA_WIDTH +: DATA_WIDTH]
- chq_ready  out  NUM_CH  channel FIFO not full
- proced_encoded_tx_data  out  DATA_WIDTH  output block
- proced_encoded_tx_hdr  out  HDR_WIDTH  output sync header
- proced_valid  out  1  output block valid
- tuser  out  TUSER_W  source: 0 = network, i+1 = channel i
- in_gap  out  1  link currently in IPG

## Operation
- Reset values: data 0, hdr 0, proced_valid 0, tuser 0, in_gap 1, chq_ready all 1, FIFOs empty, RR pointer 0.
- Gap FSM, two states: GAP (reset), FRAME. Updated only on netq_write with hdr = 2'b01 (SYNC_CTRL):
  - type 0x78/0x33/0x66 (START) -> FRAME.
  - type 0x87/0x99/0xaa/0xb4/0xcc/0xd2/0xe1/0xff (TERM) -> GAP.
  - Other types, SYNC_DATA, or illegal headers (00/11): no transition.
- Network priority: on netq_write, the block is registered to the output unchanged with tuser 0 and proced_valid 1, in any state.
- Insertion: cycle with netq_write=0, FSM in GAP (value before this edge), and ≥1 non-empty FIFO -> pop one chunk; output hdr = SYNC_CTRL, data = chunk, tuser = channel+1, proced_valid 1.
- Arbitration: round-robin starting at RR pointer; after grant to channel g, pointer = (g+1) mod NUM_CH. No grant -> pointer unchanged.
- Otherwise: proced_valid 0; data/hdr/tuser hold previous values.
- In FRAME, FIFOs hold; no pop.
- FIFO: write when chq_write[i] and not full; write to a full FIFO is dropped with no state change. Write and pop in the same cycle: count unchanged, both take effect. chq_ready[i] = !full, registered from count.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

## Timing
- Network block sampled at edge k appears on outputs after edge k (1-cycle latency).
- Chunk written at edge k is first eligible in the cycle ending at edge k+1, so its earliest output is after edge k+1.
- TERM accepted at edge k -> in_gap=1 after k; an empty net cycle at k+1 may insert.
- START accepted at edge k -> no insertion from edge k+1 onward until TERM.
- chq_ready falls in the cycle after the write that fills the FIFO.
- reset_n assertion mid-operation: all state and outputs go to reset values immediately; FIFO contents are discarded.

## Configuration
- IPG_IDLE_REPLACE_EN defined: in GAP, a network block with hdr SYNC_CTRL and type 0x1e (idle) counts as an empty slot. If any FIFO is non-empty, the idle block is dropped and a chunk is inserted in its place. If all FIFOs are empty, the idle block passes with tuser 0.
- Not defined: idle blocks are always forwarded; insertion occurs only when netq_write=0.

## Test plan
- Reset: hold reset_n=0 -> data 0, proced_valid 0, in_gap 1, chq_ready=all 1; release and idle -> no output valid.
- Gap insertion: net START (CTRL, 0x78), data 64'hbb11223344556677, TERM_1 (CTRL, 0x..aa99); write ch1 64'hccccaaaaccccaa1e during the frame -> chunk held until after TERM, then emitted on the first empty cycle with tuser 2 and hdr 01.
- Round-robin: in GAP, load ch0 A0,A1 and ch1 B0,B1, then idle net -> output order A0,B0,A1,B1 with tuser 1,2,1,2.
- Full FIFO: FIFO_DEPTH=4; write 5 chunks to ch0 while in FRAME -> chq_ready[0]=0 after the 4th write, 5th dropped; after TERM exactly 4 chunks emerge.
- Net priority in gap: net block and pending chunk in the same cycle -> net block out (tuser 0), chunk in the next empty cycle.
- IPG_IDLE_REPLACE_EN: in GAP with ch0 holding 64'h666666666666661e and net sending idle 0x1e -> chunk replaces idle (tuser 1). Macro off -> idle forwarded and chunk waits.
